lifo_stack: RTL and testbench



---
 rtl/lifo_stack.sv | 158 +++++++++++++++
 tb/tb_lifo_stack.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - pointer-addressed operand/return stack, one op per cycle
// TOS/NOS are read combinationally from the register file and masked by count.
module lifo_stack #(
  parameter int WORD  = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] din,
  input  logic            clr_err,
  output logic [WORD-1:0] peak,
  output logic [WORD-1:0] nos,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output logic            done,
  output logic            err_ovf,
  output logic            err_udf
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_DUP     = 3'd4;
  localparam logic [2:0] OP_SWAP    = 3'd5;
  localparam logic [2:0] OP_OVER    = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  logic [WORD-1:0] mem_q [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_udf_q, err_udf_d;

  logic [CW-1:0]   cnt_m1, cnt_m2;
  logic [AW-1:0]   top_idx, nos_idx, new_idx;
  logic [WORD-1:0] tos_val, nos_val;
  logic            has1, has2, at_cap;

  logic [1:0]      need;
  logic            grows, udf, ovf, exec;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   wr0_idx, wr1_idx;
  logic [WORD-1:0] wr0_data, wr1_data;

  assign cnt_m1  = count_q - CW'(1);
  assign cnt_m2  = count_q - CW'(2);
  assign top_idx = AW'(cnt_m1);
  assign nos_idx = AW'(cnt_m2);
  assign new_idx = AW'(count_q);
  assign has1    = (count_q >= CW'(1));
  assign has2    = (count_q >= CW'(2));
  assign at_cap  = (count_q == CW'(DEPTH));

  // Out-of-range slots are never shown: count gates what is visible.
  assign tos_val = has1 ? mem_q[top_idx] : '0;
  assign nos_val = has2 ? mem_q[nos_idx] : '0;

  always_comb begin
    need  = 2'd0;
    grows = 1'b0;
    unique case (op)
      OP_PUSH:    grows = 1'b1;
      OP_POP:     need  = 2'd1;
      OP_REPLACE: need  = 2'd1;
      OP_DUP:     begin need = 2'd1; grows = 1'b1; end
      OP_SWAP:    need  = 2'd2;
      OP_OVER:    begin need = 2'd2; grows = 1'b1; end
      default:    ;
    endcase
  end

  // Underflow is judged first so it masks a simultaneous capacity failure.
  assign udf  = op_valid && ((need == 2'd1 && !has1) || (need == 2'd2 && !has2));
  assign ovf  = op_valid && !udf && grows && at_cap;
  assign exec = op_valid && (op != OP_NOP) && !udf && !ovf;

  always_comb begin
    count_d  = count_q;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_idx  = new_idx;
    wr1_idx  = nos_idx;
    wr0_data = din;
    wr1_data = tos_val;
    if (exec) begin
      unique case (op)
        OP_PUSH: begin
          wr0_en  = 1'b1;
          count_d = count_q + CW'(1);
        end
        OP_POP: count_d = cnt_m1;
        OP_REPLACE: begin
          wr0_en  = 1'b1;
          wr0_idx = top_idx;
        end
        OP_DUP: begin
          wr0_en   = 1'b1;
          wr0_data = tos_val;
          count_d  = count_q + CW'(1);
        end
        OP_SWAP: begin
          wr0_en   = 1'b1;
          wr0_idx  = top_idx;
          wr0_data = nos_val;
          wr1_en   = 1'b1;
        end
        OP_OVER: begin
          wr0_en   = 1'b1;
          wr0_data = nos_val;
          count_d  = count_q + CW'(1);
        end
        OP_CLEAR: count_d = '0;
        default: ;
      endcase
    end
    done_d    = exec;
    err_ovf_d = (err_ovf_q && !clr_err) || ovf;
    err_udf_d = (err_udf_q && !clr_err) || udf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      done_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      done_q    <= done_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0_en) mem_q[wr0_idx] <= wr0_data;
      if (wr1_en) mem_q[wr1_idx] <= wr1_data;
    end
  end

  assign peak    = tos_val;
  assign nos     = nos_val;
  assign count   = count_q;
  assign full    = at_cap;
  assign empty   = !has1;
  assign done    = done_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed and random ops against a queue-based stack model
module tb_lifo_stack;
  localparam int WORD  = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst, op_valid, clr_err;
  logic [2:0]      op;
  logic [WORD-1:0] din;
  logic [WORD-1:0] peak, nos;
  logic [CW-1:0]   count;
  logic            full, empty, done, err_ovf, err_udf;

  int total = 0;
  int bad   = 0;

  logic [WORD-1:0] mq [$];
  logic            m_done, m_eo, m_eu;

  lifo_stack #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
    .clr_err(clr_err), .peak(peak), .nos(nos), .count(count), .full(full),
    .empty(empty), .done(done), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [2:0] o,
                            input logic [WORD-1:0] d, input logic c);
    int n;
    logic ok, u, f;
    logic [WORD-1:0] t;
    n = mq.size();
    ok = 0; u = 0; f = 0;
    if (r) begin
      mq.delete();
      m_eo = 0; m_eu = 0; m_done = 0;
      return;
    end
    if (v) begin
      case (o)
        3'd1: if (n >= DEPTH) f = 1; else begin mq.push_back(d); ok = 1; end
        3'd2: if (n < 1) u = 1; else begin void'(mq.pop_back()); ok = 1; end
        3'd3: if (n < 1) u = 1; else begin mq[n-1] = d; ok = 1; end
        3'd4: if (n < 1) u = 1; else if (n >= DEPTH) f = 1;
              else begin mq.push_back(mq[n-1]); ok = 1; end
        3'd5: if (n < 2) u = 1;
              else begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; ok = 1; end
        3'd6: if (n < 2) u = 1; else if (n >= DEPTH) f = 1;
              else begin mq.push_back(mq[n-2]); ok = 1; end
        3'd7: begin mq.delete(); ok = 1; end
        default: ;
      endcase
    end
    m_done = ok;
    m_eo = (m_eo && !c) || f;
    m_eu = (m_eu && !c) || u;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".peak"},  32'(peak),  (n > 0) ? 32'(mq[n-1]) : 32'd0);
    check({tag, ".nos"},   32'(nos),   (n > 1) ? 32'(mq[n-2]) : 32'd0);
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".done"},  32'(done),  32'(m_done));
    check({tag, ".eovf"},  32'(err_ovf), 32'(m_eo));
    check({tag, ".eudf"},  32'(err_udf), 32'(m_eu));
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [2:0] o,
                      input logic [WORD-1:0] d, input logic c);
    rst = r; op_valid = v; op = o; din = d; clr_err = c;
    @(posedge clk);
    model_step(r, v, o, d, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic r, v, c;
    logic [2:0] o;
    rst = 1; op_valid = 0; op = 0; din = 0; clr_err = 0;
    m_done = 0; m_eo = 0; m_eu = 0;
    step("reset", 1, 0, 3'd0, 8'h00, 0);

    step("push11", 0, 1, 3'd1, 8'h11, 0);
    step("push22", 0, 1, 3'd1, 8'h22, 0);
    step("push33", 0, 1, 3'd1, 8'h33, 0);
    check("tp1.peak", 32'(peak), 32'h33);
    check("tp1.nos",  32'(nos),  32'h22);
    step("push44", 0, 1, 3'd1, 8'h44, 0);
    step("push55", 0, 1, 3'd1, 8'h55, 0);
    check("ovf.peak", 32'(peak), 32'h44);
    check("ovf.flag", 32'(err_ovf), 32'd1);
    step("clrerr", 0, 0, 3'd0, 8'h00, 1);

    step("clear1", 0, 1, 3'd7, 8'h00, 0);
    step("p11",    0, 1, 3'd1, 8'h11, 0);
    step("p22",    0, 1, 3'd1, 8'h22, 0);
    step("swap",   0, 1, 3'd5, 8'h00, 0);
    check("swap.peak", 32'(peak), 32'h11);
    step("over",   0, 1, 3'd6, 8'h00, 0);
    step("dup",    0, 1, 3'd4, 8'h00, 0);
    check("dup.full", 32'(full), 32'd1);
    step("dupfull", 0, 1, 3'd4, 8'h00, 0);
    step("overfull", 0, 1, 3'd6, 8'h00, 0);

    step("clear2",  0, 1, 3'd7, 8'h00, 0);
    step("popempty", 0, 1, 3'd2, 8'h00, 1);
    step("dupempty", 0, 1, 3'd4, 8'h00, 0);
    check("dupempty.eovf", 32'(err_ovf), 32'd0);
    step("swap1", 0, 0, 3'd0, 8'h00, 0);
    step("pushA", 0, 1, 3'd1, 8'hA5, 0);
    step("swapn1", 0, 1, 3'd5, 8'h00, 1);
    step("repl7f", 0, 1, 3'd3, 8'h7F, 0);
    check("repl.peak", 32'(peak), 32'h7F);

    step("q1", 0, 1, 3'd1, 8'h01, 0);
    step("q2", 0, 1, 3'd1, 8'h02, 0);
    step("rstpush", 1, 1, 3'd1, 8'h99, 0);
    check("rst.count", 32'(count), 32'd0);

    for (int i = 0; i < 4; i++) step("fill", 0, 1, 3'd1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 3'd1, 8'hEE, 0);
    step("nop", 0, 1, 3'd0, 8'hEE, 0);
    step("clear4", 0, 1, 3'd7, 8'h00, 0);
    check("clear4.done", 32'(done), 32'd1);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 7) == 0);
      o = 3'($urandom_range(0, 7));
      if (o == 3'd7 && $urandom_range(0, 3) != 0) o = 3'd1;
      step("rand", r, v, o, 8'($urandom), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
